rf_writeback_queue: RTL

Writeback stage that sits directly upstream of the register file (RF). It collects destination/data results from the execute stage, buffers them in program order, and drives the RF write ports (wr_en, dst, datain). It also provides combinational forwarding of pending, not-yet-written results to the operand-read stage, which presents the same src addresses as the RF read ports.

---
 rtl/rf_writeback_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue in front of the register file: buffers execute results,
// drains them to the RF write ports and forwards pending values to operand read.
module rf_writeback_queue #(
  parameter int IN_PORTS    = 2,
  parameter int WRITE_PORTS = 1,
  parameter int READ_PORTS  = 2,
  parameter int DEPTH       = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [IN_PORTS-1:0]           res_valid,
  input  logic [IN_PORTS*ADDR_W-1:0]    res_dst,
  input  logic [IN_PORTS*DATA_W-1:0]    res_data,
  output logic                          res_ready,
  output logic [WRITE_PORTS-1:0]        wr_en,
  output logic [WRITE_PORTS*ADDR_W-1:0] dst,
  output logic [WRITE_PORTS*DATA_W-1:0] datain,
  input  logic [READ_PORTS*ADDR_W-1:0]  src,
  output logic [READ_PORTS-1:0]         fwd_hit,
  output logic [READ_PORTS*DATA_W-1:0]  fwd_data,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_dst  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [IN_PORTS-1:0] lane_push;
  logic [PTR_W-1:0]  lane_slot [IN_PORTS];
  logic [CNT_W-1:0]  push_cnt;
  logic [CNT_W-1:0]  pop_cnt;

  // Handshake: a res_* group is taken at a rising edge only while res_ready = 1;
  // valid lanes then occupy consecutive slots in lane order, invalid lanes take
  // none, and while res_ready = 0 the upstream stage holds its lanes unchanged.
  always_comb begin
    res_ready = (count <= CNT_W'(DEPTH - IN_PORTS));
    push_cnt  = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      lane_push[i] = res_valid[i] & res_ready;
      lane_slot[i] = tail + push_cnt[PTR_W-1:0];
      if (lane_push[i]) push_cnt = push_cnt + CNT_W'(1);
    end
    pop_cnt = (count > CNT_W'(WRITE_PORTS)) ? CNT_W'(WRITE_PORTS) : count;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_cnt[PTR_W-1:0];
      tail  <= tail + push_cnt[PTR_W-1:0];
      count <= count + push_cnt - pop_cnt;
    end
  end

  // Payload storage needs no reset: only slots below count are ever observed.
  always_ff @(posedge clock) begin
    for (int i = 0; i < IN_PORTS; i++) begin
      if (lane_push[i]) begin
        mem_dst[lane_slot[i]]  <= res_dst[i*ADDR_W +: ADDR_W];
        mem_data[lane_slot[i]] <= res_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < WRITE_PORTS; k++) begin
      wr_en[k]                   = (count > CNT_W'(k));
      dst[k*ADDR_W +: ADDR_W]    = mem_dst[head + PTR_W'(k)];
      datain[k*DATA_W +: DATA_W] = mem_data[head + PTR_W'(k)];
    end
  end

  // Scan oldest to youngest so the last match wins: queue head..tail-1, then lane 0, lane 1.
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      fwd_hit[r]                   = 1'b0;
      fwd_data[r*DATA_W +: DATA_W] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if ((CNT_W'(j) < count) && (mem_dst[head + PTR_W'(j)] == src[r*ADDR_W +: ADDR_W])) begin
          fwd_hit[r]                   = 1'b1;
          fwd_data[r*DATA_W +: DATA_W] = mem_data[head + PTR_W'(j)];
        end
      end
      for (int i = 0; i < IN_PORTS; i++) begin
        if (rst_n && lane_push[i] && (res_dst[i*ADDR_W +: ADDR_W] == src[r*ADDR_W +: ADDR_W])) begin
          fwd_hit[r]                   = 1'b1;
          fwd_data[r*DATA_W +: DATA_W] = res_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  count_in_range: assert property (@(posedge clock) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));

endmodule
